d_cache_fill_fsm: RTL
=====================

# d_cache_fill_fsm

Miss-handling engine on the memory side of the 2 KB, 2-way, 16 B-block data cache. On a cache miss it fetches the missing 16 B block from the pipelined main memory as eight 16-bit reads. It then writes each returned word into the selected way's data array and, with the last word, writes the tag into the metadata array. The cache controller stalls the pipeline while `fsm_busy` is high.

## Interface
Parameters:
- `MEM_LATENCY`, 4: cycles from a memory read request to its `memory_data_valid` return; fixed and pipelined, one request accepted per cycle.
- `WORDS_PER_BLOCK`, 8: 16-bit words per cache block; fixed at 8.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset; also resets main memory, flushing in-flight reads.
- `miss_detected`  in  1  cache miss; held high by the controller until `fsm_busy` falls.
- `miss_address`  in  16  byte address of the miss; stable while `miss_detected` is high.
- `memory_data_valid`  in  1  returned read data valid this cycle.
- `memory_data`  in  16  returned read data.
- `fsm_busy`  out  1  fill in progress.
- `mem_read_en`  out  1  issue a memory read this cycle.
- `memory_address`  out  16  word-aligned read address.
- `write_data_array`  out  1  write `fill_data` into the data array this cycle.
- `fill_word_en`  out  8  one-hot word enable for the data array write.
- `fill_data`  out  16  word to write; equals `memory_data`.
- `fill_set`  out  6  set index of the block being filled, `miss_address[9:4]`.
- `write_tag_array`  out  1  write `fill_tag` into the metadata array this cycle.
- `fill_tag`  out  8  `{base[15:10], 1'b1 (valid), 1'b0 (LRU, owned by controller)}`.
- `fill_done`  out  1  one-cycle registered pulse in the cycle after the final write.

## Operation
- States: IDLE, FILL.
- IDLE:
  - On `miss_detected`, capture `base = {miss_address[15:4], 4'b0}`.
  - Clear `issue_cnt` and `recv_cnt` (4 bits each, range 0..8).
  - Go to FILL.
- FILL, request side:
  - `mem_read_en = (issue_cnt < 8)`.
  - `memory_address = base + {issue_cnt[2:0], 1'b0}`; addresses never cross the block.
  - `issue_cnt` increments on each request.
- FILL, return side, on `memory_data_valid`:
  - `write_data_array = 1`, `fill_word_en = 8'b1 << recv_cnt[2:0]`, `fill_data = memory_data`.
  - `recv_cnt` increments.
- Last word (`memory_data_valid && recv_cnt == 7`):
  - `write_tag_array = 1` in the same cycle.
  - Next state is IDLE; `fill_done = 1` the following cycle.
- `fsm_busy = (state == FILL)`.
- `write_data_array`, `write_tag_array`, `mem_read_en` and `fill_word_en` are 0 in IDLE.
- `fill_set` and `fill_tag` are always derived from the captured `base`.
- Ignored events:
  - `memory_data_valid` while in IDLE.
  - `memory_data_valid` after `recv_cnt` reaches 8.
  - `miss_detected` while in FILL; no re-capture.
- `miss_detected` still high in the cycle after `fill_done`: the controller has not yet re-checked. The block starts a new fill, which is legal; the controller deasserts `miss_detected` on the hit.

## Timing
- Reset: state IDLE, counters 0, `base` 0, every output 0 (`fill_tag` = 8'h02, since its valid bit is constant 1).
- Reset mid-fill aborts with no further array writes; returns from the old fill are discarded because memory is reset too.
- Miss sampled at edge T0:
  - Requests in cycles 1..8.
  - Data and data-array writes in cycles 1+`MEM_LATENCY` .. 8+`MEM_LATENCY` (5..12 at default).
  - Tag write in cycle 12; `fsm_busy` high in cycles 1..12; `fill_done` in cycle 13.
- Total miss penalty is 12 busy cycles at default.
- All control outputs are combinational from state, counters and `memory_data_valid`; no added latency.

## Test plan
- Miss at 16'h1A37 with `MEM_LATENCY`=4:
  - Requests to 16'h1A30, 1A32 … 1A3E in cycles 1..8.
  - Words return as 16'h0000..0007; `fill_word_en` runs 01,02 … 80 in cycles 5..12.
  - `fill_set` = 6'h23; `fill_tag` = {6'h06,2'b10} = 8'h1A.
  - `write_tag_array` in cycle 12; `fill_done` in cycle 13.
- Reset asserted in cycle 6 of a fill: all outputs 0 next cycle; no writes afterwards; a new miss then fills normally.
- `memory_data_valid` pulsed while IDLE and a 9th valid in FILL: no array writes, no count change.
- `miss_detected` toggled to a different address mid-fill: `memory_address`, `fill_set` and `fill_tag` stay on the original block.
- Back-to-back misses 16'h0000 then 16'hFFF0 (`miss_detected` held through `fill_done`): second fill starts in cycle 13, and its address wraps within 16'hFFF0..FFFE.

Source files
------------

// File: rtl/d_cache_fill_fsm.sv
// Miss-handling engine for the 2-way, 16 B-block data cache: fetches one block as eight
// pipelined 16-bit reads, writes each returned word into the data array, then writes the tag.
module d_cache_fill_fsm #(
   parameter int MEM_LATENCY     = 4,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   input  logic [15:0] memory_data,
   output logic        fsm_busy,
   output logic        mem_read_en,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [7:0]  fill_word_en,
   output logic [15:0] fill_data,
   output logic [5:0]  fill_set,
   output logic        write_tag_array,
   output logic [7:0]  fill_tag,
   output logic        fill_done
);

   localparam logic [3:0] NWORDS = 4'(WORDS_PER_BLOCK);
   localparam logic [3:0] LAST   = 4'(WORDS_PER_BLOCK - 1);
   // A genuine return cannot precede the MEM_LATENCY-th request (or the last one).
   localparam logic [3:0] RX_MIN = 4'((MEM_LATENCY < WORDS_PER_BLOCK) ? MEM_LATENCY
                                                                       : WORDS_PER_BLOCK);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [11:0] base_q, base_d;     // block address bits [15:4]
   logic [3:0]  issue_q, issue_d;
   logic [3:0]  recv_q, recv_d;
   logic        done_q, done_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^miss_address[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         issue_q <= '0;
         recv_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      issue_d          = issue_q;
      recv_d           = recv_q;
      done_d           = 1'b0;
      mem_read_en      = 1'b0;
      write_data_array = 1'b0;
      fill_word_en     = '0;
      write_tag_array  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (miss_detected) begin
               base_d  = miss_address[15:4];
               issue_d = '0;
               recv_d  = '0;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (issue_q < NWORDS) begin
               mem_read_en = 1'b1;
               issue_d     = issue_q + 4'd1;
            end
            if (memory_data_valid && (recv_q < NWORDS) && (issue_q >= RX_MIN)) begin
               write_data_array = 1'b1;
               fill_word_en     = 8'b1 << recv_q[2:0];
               recv_d           = recv_q + 4'd1;
               if (recv_q == LAST) begin
                  write_tag_array = 1'b1;
                  done_d          = 1'b1;
                  state_d         = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Low address bits come from the word counter, so reads wrap inside the block.
   assign memory_address = {base_q, issue_q[2:0], 1'b0};
   assign fsm_busy       = (state_q == S_FILL);
   assign fill_data      = memory_data;
   assign fill_set       = base_q[5:0];
   assign fill_tag       = {base_q[11:6], 2'b10};
   assign fill_done      = done_q;

endmodule
